// File: rtl/alu_serial_sequencer.sv
// Host-side sequencer for the serial TMR ALU: shifts {OP,A,B} MSB-first, strobes READY, waits, then captures the result.
// Optional macro SEQ_CHECK_EN adds a CHECK state that re-samples the ALU one edge later and flags differences on ERR.
module alu_serial_sequencer #(
  parameter int FRAME_W = 20,
  parameter int RES_LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic [3:0]  OP,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RESULT,
  output logic [14:0] RESULT_2,
  output logic        CARRY,
  output logic        ERR,
  output logic        ALU_DATA,
  output logic        ALU_READY,
  input  logic [15:0] ALU_OUT,
  input  logic [14:0] ALU_OUT_2,
  input  logic        ALU_COUT
);

  localparam int BCW = $clog2(FRAME_W + 1);
  localparam int WCW = $clog2(RES_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FIRE,
    ST_WAIT
`ifdef SEQ_CHECK_EN
    , ST_CHECK
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]     wait_cnt_q, wait_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               alu_data_q, alu_data_d;
  logic               alu_ready_q, alu_ready_d;
  logic [15:0]        result_q, result_d;
  logic [14:0]        result2_q, result2_d;
  logic               carry_q, carry_d;
  logic [FRAME_W-1:0] frame_in;
  logic [31:0]        alu_smp;

  assign frame_in = FRAME_W'({OP, A, B});
  assign alu_smp  = {ALU_COUT, ALU_OUT_2, ALU_OUT};

`ifdef SEQ_CHECK_EN
  logic [31:0] samp_q, samp_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    alu_data_d  = 1'b0;
    alu_ready_d = 1'b0;
    result_d    = result_q;
    result2_d   = result2_q;
    carry_d     = carry_q;
`ifdef SEQ_CHECK_EN
    samp_d      = samp_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // The DONE cycle is an IDLE cycle, so back-to-back requests land here too.
        if (REQ) begin
          state_d    = ST_SHIFT;
          shift_d    = {frame_in[FRAME_W-2:0], 1'b0};
          alu_data_d = frame_in[FRAME_W-1];
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == BCW'(FRAME_W - 1)) begin
          state_d     = ST_FIRE;
          alu_ready_d = 1'b1;
        end else begin
          alu_data_d = shift_q[FRAME_W-1];
          shift_d    = shift_q << 1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end
      end
      ST_FIRE: begin
        state_d    = ST_WAIT;
        wait_cnt_d = '0;
      end
      ST_WAIT: begin
        if (wait_cnt_q == WCW'(RES_LAT - 1)) begin
`ifdef SEQ_CHECK_EN
          state_d = ST_CHECK;
          samp_d  = alu_smp;
`else
          state_d                         = ST_IDLE;
          {carry_d, result2_d, result_d}  = alu_smp;
          done_d                          = 1'b1;
          busy_d                          = 1'b0;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
`ifdef SEQ_CHECK_EN
      ST_CHECK: begin
        // Result keeps the later sample; ERR reports any drift since the first.
        state_d                        = ST_IDLE;
        {carry_d, result2_d, result_d} = alu_smp;
        err_d                          = (samp_q != alu_smp);
        done_d                         = 1'b1;
        busy_d                         = 1'b0;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      alu_data_q  <= 1'b0;
      alu_ready_q <= 1'b0;
      result_q    <= '0;
      result2_q   <= '0;
      carry_q     <= 1'b0;
`ifdef SEQ_CHECK_EN
      samp_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      alu_data_q  <= alu_data_d;
      alu_ready_q <= alu_ready_d;
      result_q    <= result_d;
      result2_q   <= result2_d;
      carry_q     <= carry_d;
`ifdef SEQ_CHECK_EN
      samp_q      <= samp_d;
      err_q       <= err_d;
`endif
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign RESULT_2  = result2_q;
  assign CARRY     = carry_q;
  assign ALU_DATA  = alu_data_q;
  assign ALU_READY = alu_ready_q;
`ifdef SEQ_CHECK_EN
  assign ERR       = err_q;
`else
  assign ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Self-checking bench for alu_serial_sequencer: edge-count transaction model, bench-side serial ALU, directed vectors.
module tb_alu_serial_sequencer;

  localparam int FW = 20;
  localparam int RL = 2;
`ifdef SEQ_CHECK_EN
  localparam int DONE_E = FW + 1 + RL + 1;
  localparam logic [31:0] GL_MASK = 32'h0000_0001;
`else
  localparam int DONE_E = FW + 1 + RL;
  localparam logic [31:0] GL_MASK = 32'h0000_0000;
`endif
  localparam int PERIOD = DONE_E + 1;

  logic        CLK, RST, REQ;
  logic [3:0]  OP;
  logic [7:0]  A, B;
  logic        BUSY, DONE, CARRY, ERR, ALU_DATA, ALU_READY;
  logic [15:0] RESULT;
  logic [14:0] RESULT_2;
  logic [15:0] ALU_OUT = '0;
  logic [14:0] ALU_OUT_2 = '0;
  logic        ALU_COUT = 1'b0;

  alu_serial_sequencer #(.FRAME_W(FW), .RES_LAT(RL)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .OP(OP), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .RESULT_2(RESULT_2),
    .CARRY(CARRY), .ERR(ERR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .ALU_OUT(ALU_OUT), .ALU_OUT_2(ALU_OUT_2), .ALU_COUT(ALU_COUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ALU behaviour used both by the bench-side ALU and the model: {COUT, OUT_2, OUT}.
  function automatic logic [31:0] alu_fn(input logic [19:0] f);
    logic [7:0]  a, b;
    logic [15:0] o;
    logic        c;
    a = f[15:8];
    b = f[7:0];
    case (f[19:16])
      4'h1:    begin o = 16'(a) + 16'(b); c = o[8]; end
      4'h2:    begin o = 16'(a) - 16'(b); c = (a < b); end
      default: begin o = {a, b};          c = ^{a, b}; end
    endcase
    return {c, 15'(16'(a) * 16'(b)), o};
  endfunction

  // Transaction model: everything follows from the edge count since acceptance.
  int          edge_no = 0;
  int          acc = -1000;
  logic [19:0] m_frame = '0;
  logic        m_glitch = 1'b0;
  logic        glitch_req = 1'b0;
  logic [15:0] m_res = '0;
  logic [14:0] m_res2 = '0;
  logic        m_carry = 1'b0;
  logic        m_err = 1'b0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc = -1000;
      m_res = '0; m_res2 = '0; m_carry = 1'b0; m_err = 1'b0;
    end else begin
      edge_no++;
      if (edge_no - acc == DONE_E) begin
        {m_carry, m_res2, m_res} = alu_fn(m_frame) ^ (m_glitch ? GL_MASK : 32'h0);
        m_err = m_glitch;
      end
      if (edge_no - acc > DONE_E && REQ) begin
        acc = edge_no;
        m_frame = {OP, A, B};
        m_glitch = glitch_req;
      end
    end
  end

  // Bench-side serial ALU: collects bits until READY, then drives its outputs.
  logic [19:0] alu_sh = '0;
  logic [19:0] alu_rx = '0;
  int          alu_cnt = -1;
  always @(negedge CLK) begin
    if (ALU_READY) begin
      alu_rx = alu_sh;
      {ALU_COUT, ALU_OUT_2, ALU_OUT} = alu_fn(alu_sh);
      alu_cnt = 0;
    end else begin
      alu_sh = {alu_sh[18:0], ALU_DATA};
      if (alu_cnt >= 0) alu_cnt++;
      if (alu_cnt == 3 && m_glitch)
        {ALU_COUT, ALU_OUT_2, ALU_OUT} = {ALU_COUT, ALU_OUT_2, ALU_OUT} ^ GL_MASK;
    end
  end

  // Per-cycle comparison of every output against the model.
  int done_cnt = 0;
  int last_done_edge = -1;
  int done_gap = 0;
  always @(negedge CLK) begin
    int t;
    t = edge_no - acc;
    chk("busy",  32'(BUSY),      32'(t >= 0 && t < DONE_E));
    chk("ready", 32'(ALU_READY), 32'(t == FW));
    chk("done",  32'(DONE),      32'(t == DONE_E));
    if (t >= 0 && t < FW) chk("data", 32'(ALU_DATA), 32'(m_frame[FW-1-t]));
    else                  chk("data", 32'(ALU_DATA), 32'h0);
    chk("result",   32'(RESULT),   32'(m_res));
    chk("result_2", 32'(RESULT_2), 32'(m_res2));
    chk("carry",    32'(CARRY),    32'(m_carry));
    chk("err",      32'(ERR),      32'(m_err));
    if (DONE) begin
      done_cnt++;
      if (last_done_edge >= 0) done_gap = edge_no - last_done_edge;
      last_done_edge = edge_no;
    end
  end

  task automatic go(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    OP = op; A = a; B = b; REQ = 1'b1;
    @(negedge CLK);
    REQ = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int d0;

  initial begin
    RST = 1'b0; REQ = 1'b0; OP = '0; A = '0; B = '0;
    idle(3);
    chk("rst_busy",   32'(BUSY),   32'h0);
    chk("rst_result", 32'(RESULT), 32'h0);
    RST = 1'b1;
    idle(2);

    // Add 0x0F+0x35: frame 0x10F35, result 0x0044.
    go(4'h1, 8'h0F, 8'h35);
    idle(DONE_E + 2);
    chk("frame1",    32'(alu_rx),   32'h0001_0F35);
    chk("add_res",   32'(RESULT),   32'h0044);
    chk("add_res2",  32'(RESULT_2), 32'h031B);
    chk("add_carry", 32'(CARRY),    32'h0);
    chk("done_lat",  32'(last_done_edge - acc), 32'(DONE_E));

    // Sum carry.
    go(4'h1, 8'hFF, 8'h01);
    idle(DONE_E + 2);
    chk("cy_res",   32'(RESULT),   32'h0100);
    chk("cy_res2",  32'(RESULT_2), 32'h00FF);
    chk("cy_carry", 32'(CARRY),    32'h1);

    // REQ held high for exactly three acceptances; operands change every cycle.
    d0 = done_cnt;
    @(negedge CLK);
    OP = 4'h1; A = 8'h11; B = 8'h22; REQ = 1'b1;
    for (int i = 0; i < 2 * PERIOD + 1; i++) begin
      @(negedge CLK);
      OP = 4'($urandom_range(1, 3)); A = 8'($urandom); B = 8'($urandom);
    end
    REQ = 1'b0;
    idle(DONE_E + 2);
    chk("held_dones", 32'(done_cnt - d0), 32'd3);
    chk("held_gap",   32'(done_gap),      32'(PERIOD));

    // REQ and operands toggled while busy: one DONE, original operands.
    d0 = done_cnt;
    go(4'h2, 8'h50, 8'h20);
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      REQ = ~REQ; OP = 4'($urandom); A = 8'($urandom); B = 8'($urandom);
    end
    REQ = 1'b0;
    idle(DONE_E + 2);
    chk("tog_dones", 32'(done_cnt - d0), 32'd1);
    chk("tog_res",   32'(RESULT),        32'h0030);
    chk("tog_carry", 32'(CARRY),         32'h0);

    // Asynchronous reset during shift cycle 10.
    d0 = done_cnt;
    go(4'h1, 8'h12, 8'h34);
    idle(10);
    #2 RST = 1'b0;
    #1;
    chk("arst_outs", {BUSY, DONE, CARRY, ERR, ALU_DATA, ALU_READY}, 32'h0);
    chk("arst_res",  {RESULT, 1'b0, RESULT_2}, 32'h0);
    idle(2);
    RST = 1'b1;
    idle(DONE_E + 2);
    chk("arst_nodone", 32'(done_cnt - d0), 32'd0);
    go(4'h3, 8'hA5, 8'h3C);
    idle(DONE_E + 2);
    chk("frame_post", 32'(alu_rx), 32'h0003_A53C);
    chk("res_post",   32'(RESULT), 32'h0000_A53C);

`ifdef SEQ_CHECK_EN
    // ALU outputs drift between the two sample edges.
    glitch_req = 1'b1;
    go(4'h1, 8'h0F, 8'h35);
    glitch_req = 1'b0;
    idle(DONE_E + 2);
    chk("chk_err",  32'(ERR),    32'h1);
    chk("chk_res",  32'(RESULT), 32'h0045);
    chk("chk_lat",  32'(last_done_edge - acc), 32'd24);
    go(4'h1, 8'h0F, 8'h35);
    idle(DONE_E + 2);
    chk("chk_ok",   32'(ERR),    32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
